// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the cache-to-memory arbiter and its clients.
// Width defaults must match the instruction and data caches.
package mem_arbiter_pkg;

    localparam int unsigned AddrWidth = 28;
    localparam int unsigned DataWidth = 128;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StGntI = 2'd1,
        StGntD = 2'd2
    } arb_state_e;

    typedef logic master_id_t;

    localparam master_id_t MasterI = 1'b0;
    localparam master_id_t MasterD = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: on contention, the master not served last wins.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       req_ic,
    input  logic       req_dc,
    input  master_id_t last_grant,
    output logic       gnt_valid,
    output master_id_t gnt_id
);

    always_comb begin
        gnt_valid = req_ic | req_dc;
        gnt_id    = MasterI;
        if (req_ic && req_dc) begin
            gnt_id = (last_grant == MasterI) ? MasterD : MasterI;
        end else if (req_dc) begin
            gnt_id = MasterD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates I-cache and D-cache block requests onto one memory port, holding
// the granted command stable until mem_ready, with an optional sticky watchdog.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = AddrWidth,
    parameter int unsigned DATA_W      = DataWidth,
    parameter int unsigned WDOG_CYCLES = 0
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              mem_timeout
);

    localparam bit          WdogEn = (WDOG_CYCLES != 0);
    localparam int unsigned CntW   = WdogEn ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WDOG_CYCLES);

    arb_state_e        state_q, state_d;
    master_id_t        last_grant_q, last_grant_d;
    logic              cmd_read_q, cmd_read_d;
    logic              cmd_write_q, cmd_write_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [CntW-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic              timeout_q, timeout_d;
    logic              gnt_valid;
    master_id_t        gnt_id;
    logic              busy;

    rr_arbiter2 u_rr (
        .req_ic     (ic_mem_read),
        .req_dc     (dc_mem_read | dc_mem_write),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign busy = (state_q != StIdle);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cmd_read_d   = cmd_read_q;
        cmd_write_d  = cmd_write_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_wdata_d  = cmd_wdata_q;
        case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    last_grant_d = gnt_id;
                    if (gnt_id == MasterD) begin
                        state_d     = StGntD;
                        cmd_addr_d  = dc_mem_addr;
                        cmd_wdata_d = dc_mem_wdata;
                        cmd_write_d = dc_mem_write;
                        cmd_read_d  = ~dc_mem_write;
                    end else begin
                        state_d     = StGntI;
                        cmd_addr_d  = ic_mem_addr;
                        cmd_wdata_d = '0;
                        cmd_write_d = 1'b0;
                        cmd_read_d  = 1'b1;
                    end
                end
            end
            StGntI, StGntD: begin
                // Always run to completion, even if the owner has dropped its request.
                if (mem_ready) begin
                    state_d     = StIdle;
                    cmd_read_d  = 1'b0;
                    cmd_write_d = 1'b0;
                    cmd_addr_d  = '0;
                    cmd_wdata_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wdog_cnt_d = '0;
        timeout_d  = timeout_q;
        if (WdogEn && busy && !mem_ready) begin
            wdog_cnt_d = (wdog_cnt_q == CntMax) ? wdog_cnt_q : wdog_cnt_q + CntW'(1);
            if (wdog_cnt_d == CntMax) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q      <= StIdle;
            last_grant_q <= MasterI;
            cmd_read_q   <= 1'b0;
            cmd_write_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            wdog_cnt_q   <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cmd_read_q   <= cmd_read_d;
            cmd_write_q  <= cmd_write_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            wdog_cnt_q   <= wdog_cnt_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_read     = busy & cmd_read_q;
    assign mem_write    = busy & cmd_write_q;
    assign mem_addr     = busy ? cmd_addr_q : '0;
    assign mem_wdata    = busy ? cmd_wdata_q : '0;
    assign ic_mem_ready = (state_q == StGntI) & mem_ready;
    assign dc_mem_ready = (state_q == StGntD) & mem_ready;
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    assign mem_timeout  = timeout_q;

endmodule
